// File: rtl/sdram_pkg.sv
// Shared state encoding and default widths for the Avalon-MM burst mover.
package sdram_pkg;

   localparam int ADDR_W = 25;
   localparam int DATA_W = 32;
   localparam int LEN_W  = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_RD_ISSUE,
      S_RD_DRAIN,
      S_DONE
   } state_t;

endpackage

// File: rtl/avm_outstanding_ctr.sv
// Counts reads issued on the bus but not yet returned; saturation is the caller's job via full_o.
module avm_outstanding_ctr #(
   parameter int MAX_OUTSTANDING = 8,
   parameter int WIDTH           = $clog2(MAX_OUTSTANDING) + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [WIDTH-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam logic [WIDTH-1:0] MaxCount = WIDTH'(MAX_OUTSTANDING);

   logic [WIDTH-1:0] count_q, count_d;

   // An issue and a return in the same cycle cancel out.
   always_comb begin
      count_d = count_q;
      if (inc_i && !dec_i) begin
         count_d = count_q + 1'b1;
      end else if (dec_i && !inc_i) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign full_o  = (count_q == MaxCount);
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/avm_burst_mover.sv
// Avalon-MM master moving a run of single-word beats between SDRAM and the local datapath,
// with waitrequest handling and a bounded number of pipelined reads in flight.
module avm_burst_mover #(
   parameter int ADDR_W          = sdram_pkg::ADDR_W,
   parameter int DATA_W          = sdram_pkg::DATA_W,
   parameter int LEN_W           = sdram_pkg::LEN_W,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_cmd_valid,
   output logic                o_cmd_ready,
   input  logic                i_cmd_write,
   input  logic [ADDR_W-1:0]   i_cmd_addr,
   input  logic [LEN_W-1:0]    i_cmd_len,
   input  logic [DATA_W-1:0]   i_wr_data,
   input  logic                i_wr_valid,
   output logic                o_wr_ready,
   output logic [DATA_W-1:0]   o_rd_data,
   output logic                o_rd_valid,
   output logic                o_busy,
   output logic                o_done,
   output logic [ADDR_W-1:0]   o_avm_address,
   output logic [DATA_W/8-1:0] o_avm_byteenable,
   output logic                o_avm_chipselect,
   output logic [DATA_W-1:0]   o_avm_writedata,
   output logic                o_avm_read,
   output logic                o_avm_write,
   input  logic [DATA_W-1:0]   i_avm_readdata,
   input  logic                i_avm_readdatavalid,
   input  logic                i_avm_waitrequest
);

   import sdram_pkg::*;

   localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
   localparam logic [LEN_W-1:0] LenOne = LEN_W'(1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LEN_W-1:0]    beats_q, beats_d;
   logic [LEN_W-1:0]    rets_q, rets_d;
   logic                rd_valid_q;
   logic [DATA_W-1:0]   rd_data_q;

   logic                avm_read, avm_write, wr_ready, rd_issue, rd_ret;
   logic [CNT_W-1:0]    out_count;
   logic                out_full, out_empty;

   // Returns with nothing in flight (e.g. late data after an abort) are dropped here.
   assign rd_ret = i_avm_readdatavalid && !out_empty;

   avm_outstanding_ctr #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .WIDTH           (CNT_W)
   ) u_outstanding (
      .clk_i   (i_clk),
      .rst_i   (i_rst),
      .inc_i   (rd_issue),
      .dec_i   (rd_ret),
      .count_o (out_count),
      .full_o  (out_full),
      .empty_o (out_empty)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      beats_d   = beats_q;
      rets_d    = rets_q;
      avm_read  = 1'b0;
      avm_write = 1'b0;
      wr_ready  = 1'b0;
      rd_issue  = 1'b0;

      if (rd_ret) begin
         rets_d = rets_q - 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (i_cmd_valid) begin
               addr_d  = i_cmd_addr;
               beats_d = i_cmd_len;
               rets_d  = i_cmd_len;
               if (i_cmd_len == '0) begin
                  state_d = S_DONE;
               end else if (i_cmd_write) begin
                  state_d = S_WRITE;
               end else begin
                  state_d = S_RD_ISSUE;
               end
            end
         end
         S_WRITE: begin
            avm_write = i_wr_valid;
            wr_ready  = i_wr_valid && !i_avm_waitrequest;
            if (wr_ready) begin
               addr_d  = addr_q + 1'b1;
               beats_d = beats_q - 1'b1;
               if (beats_q == LenOne) begin
                  state_d = S_DONE;
               end
            end
         end
         S_RD_ISSUE: begin
            avm_read = !out_full;
            rd_issue = avm_read && !i_avm_waitrequest;
            if (rd_issue) begin
               addr_d  = addr_q + 1'b1;
               beats_d = beats_q - 1'b1;
               if (beats_q == LenOne) begin
                  state_d = S_RD_DRAIN;
               end
            end
         end
         S_RD_DRAIN: begin
            if (out_count == '0 && rets_q == '0) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         beats_q    <= '0;
         rets_q     <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         beats_q    <= beats_d;
         rets_q     <= rets_d;
         rd_valid_q <= rd_ret;
         if (rd_ret) begin
            rd_data_q <= i_avm_readdata;
         end
      end
   end

   assign o_cmd_ready      = (state_q == S_IDLE);
   assign o_busy           = (state_q == S_WRITE) || (state_q == S_RD_ISSUE) || (state_q == S_RD_DRAIN);
   assign o_done           = (state_q == S_DONE);
   assign o_wr_ready       = wr_ready;
   assign o_rd_valid       = rd_valid_q;
   assign o_rd_data        = rd_data_q;
   assign o_avm_read       = avm_read;
   assign o_avm_write      = avm_write;
   assign o_avm_chipselect = avm_read || avm_write;
   assign o_avm_byteenable = (avm_read || avm_write) ? '1 : '0;
   assign o_avm_writedata  = avm_write ? i_wr_data : '0;
   assign o_avm_address    = addr_q;

endmodule

// File: tb/tb_avm_burst_mover.sv
// Directed bench for avm_burst_mover: one DUT with 8 reads in flight, one limited to 2,
// each fed by a fixed-latency Avalon slave model.
module tb_avm_burst_mover;

   localparam int AW = 25;
   localparam int DW = 32;
   localparam int LW = 8;

   typedef struct {
      int            due;
      logic [DW-1:0] data;
   } ret_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic          cmdValid8 = 1'b0, cmdValid2 = 1'b0, cmdWrite = 1'b0;
   logic [AW-1:0] cmdAddr = '0;
   logic [LW-1:0] cmdLen = '0;
   logic [DW-1:0] wrData = '0;
   logic          wrValid = 1'b0, waitReq = 1'b0;

   logic          cmdReady8, wrReady8, rdValid8, busy8, done8, avmRead8, avmWrite8, cs8;
   logic [DW-1:0] rdData8, wdata8;
   logic [AW-1:0] addr8;
   logic [DW/8-1:0] be8;
   logic [DW-1:0] rdd8 = '0;
   logic          rdv8 = 1'b0;

   logic          cmdReady2, wrReady2, rdValid2, busy2, done2, avmRead2, avmWrite2, cs2;
   logic [DW-1:0] rdData2, wdata2;
   logic [AW-1:0] addr2;
   logic [DW/8-1:0] be2;
   logic [DW-1:0] rdd2 = '0;
   logic          rdv2 = 1'b0;

   int            cyc = 0;
   int            lat8 = 3, lat2 = 10;
   int            maxOut8 = 0, maxOut2 = 0, viol2 = 0, fullStall2 = 0;
   int            doneCnt8 = 0, doneCnt2 = 0;
   ret_t          q8[$], q2[$];
   logic [DW-1:0] rdQ8[$], rdQ2[$];
   logic [AW-1:0] issAddr8[$];
   int            total = 0, bad = 0;

   avm_burst_mover #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .MAX_OUTSTANDING(8)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_cmd_valid(cmdValid8), .o_cmd_ready(cmdReady8), .i_cmd_write(cmdWrite),
      .i_cmd_addr(cmdAddr), .i_cmd_len(cmdLen),
      .i_wr_data(wrData), .i_wr_valid(wrValid), .o_wr_ready(wrReady8),
      .o_rd_data(rdData8), .o_rd_valid(rdValid8), .o_busy(busy8), .o_done(done8),
      .o_avm_address(addr8), .o_avm_byteenable(be8), .o_avm_chipselect(cs8),
      .o_avm_writedata(wdata8), .o_avm_read(avmRead8), .o_avm_write(avmWrite8),
      .i_avm_readdata(rdd8), .i_avm_readdatavalid(rdv8), .i_avm_waitrequest(waitReq)
   );

   avm_burst_mover #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .MAX_OUTSTANDING(2)) dut2 (
      .i_clk(clk), .i_rst(rst),
      .i_cmd_valid(cmdValid2), .o_cmd_ready(cmdReady2), .i_cmd_write(cmdWrite),
      .i_cmd_addr(cmdAddr), .i_cmd_len(cmdLen),
      .i_wr_data(wrData), .i_wr_valid(wrValid), .o_wr_ready(wrReady2),
      .o_rd_data(rdData2), .o_rd_valid(rdValid2), .o_busy(busy2), .o_done(done2),
      .o_avm_address(addr2), .o_avm_byteenable(be2), .o_avm_chipselect(cs2),
      .o_avm_writedata(wdata2), .o_avm_read(avmRead2), .o_avm_write(avmWrite2),
      .i_avm_readdata(rdd2), .i_avm_readdatavalid(rdv2), .i_avm_waitrequest(waitReq)
   );

   function automatic logic [DW-1:0] memWord(input logic [AW-1:0] a);
      return {7'h2D, a};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Slave models: queue length before this cycle's pop equals reads the DUT still has in flight.
   always @(negedge clk) begin
      rdv8 = 1'b0;
      if (q8.size() > maxOut8) maxOut8 = q8.size();
      if (q8.size() > 0 && q8[0].due <= cyc) begin
         rdv8 = 1'b1;
         rdd8 = q8[0].data;
         void'(q8.pop_front());
      end
      if (avmRead8 && !waitReq) begin
         q8.push_back('{due: cyc + lat8, data: memWord(addr8)});
         issAddr8.push_back(addr8);
      end
      if (rdValid8) rdQ8.push_back(rdData8);
      if (done8) doneCnt8++;
   end

   always @(negedge clk) begin
      rdv2 = 1'b0;
      if (q2.size() > maxOut2) maxOut2 = q2.size();
      if (q2.size() >= 2 && avmRead2) viol2++;
      if (q2.size() >= 2 && busy2 && !avmRead2) fullStall2++;
      if (q2.size() > 0 && q2[0].due <= cyc) begin
         rdv2 = 1'b1;
         rdd2 = q2[0].data;
         void'(q2.pop_front());
      end
      if (avmRead2 && !waitReq) q2.push_back('{due: cyc + lat2, data: memWord(addr2)});
      if (rdValid2) rdQ2.push_back(rdData2);
      if (done2) doneCnt2++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, want);
      end
   endtask

   task automatic applyStimulus(input bit toDut2, input bit wr, input logic [AW-1:0] a,
                                input logic [LW-1:0] n);
      cmdWrite  = wr;
      cmdAddr   = a;
      cmdLen    = n;
      cmdValid8 = !toDut2;
      cmdValid2 = toDut2;
      step();
      cmdValid8 = 1'b0;
      cmdValid2 = 1'b0;
   endtask

   task automatic waitDone(input bit onDut2, input int budget, input string tag);
      bit seen = 1'b0;
      for (int c = 0; c < budget && !seen; c++) begin
         #1;
         if (onDut2 ? done2 : done8) seen = 1'b1;
         step();
      end
      checkOutput(tag, 64'(seen), 64'd1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int s, si, d0, pat, k;
      logic [AW-1:0] wrapExp [4];
      wrapExp[0] = 25'h1FF_FFFE;
      wrapExp[1] = 25'h1FF_FFFF;
      wrapExp[2] = 25'h000_0000;
      wrapExp[3] = 25'h000_0001;

      step();
      step();
      #1;
      checkOutput("rst cmd_ready", 64'(cmdReady8), 64'd1);
      checkOutput("rst busy", 64'(busy8), 64'd0);
      checkOutput("rst done", 64'(done8), 64'd0);
      checkOutput("rst rd/wr", 64'({avmRead8, avmWrite8, cs8}), 64'd0);
      checkOutput("rst byteenable", 64'(be8), 64'd0);
      checkOutput("rst rd_valid", 64'(rdValid8), 64'd0);
      checkOutput("rst address", 64'(addr8), 64'd0);
      checkOutput("rst cmd_ready2", 64'(cmdReady2), 64'd1);
      rst = 1'b0;
      step();

      // Streaming write: one beat per cycle, done the cycle after the last beat.
      wrValid = 1'b1;
      wrData  = 32'hD000_0000;
      applyStimulus(1'b0, 1'b1, 25'h10, 8'd4);
      for (int i = 0; i < 4; i++) begin
         #1;
         checkOutput("wr1 write", 64'(avmWrite8), 64'd1);
         checkOutput("wr1 address", 64'(addr8), 64'(25'h10 + i));
         checkOutput("wr1 writedata", 64'(wdata8), 64'(32'hD000_0000 + i));
         checkOutput("wr1 wr_ready", 64'(wrReady8), 64'd1);
         checkOutput("wr1 byteenable", 64'(be8), 64'hF);
         step();
         wrData = 32'hD000_0000 + 32'(i + 1);
      end
      #1;
      checkOutput("wr1 done", 64'(done8), 64'd1);
      checkOutput("wr1 busy at done", 64'(busy8), 64'd0);
      checkOutput("wr1 write at done", 64'(avmWrite8), 64'd0);
      step();
      #1;
      checkOutput("wr1 done cleared", 64'(done8), 64'd0);
      checkOutput("wr1 cmd_ready back", 64'(cmdReady8), 64'd1);
      step();

      // Second beat stalled for three cycles by waitrequest.
      pat = 'b0001110;
      k = 0;
      applyStimulus(1'b0, 1'b1, 25'h40, 8'd4);
      for (int c = 0; c < 7; c++) begin
         waitReq = pat[c];
         wrData  = 32'hE000_0000 + 32'(k);
         #1;
         checkOutput("wr2 address", 64'(addr8), 64'(25'h40 + k));
         checkOutput("wr2 writedata", 64'(wdata8), 64'(32'hE000_0000 + k));
         checkOutput("wr2 write", 64'(avmWrite8), 64'd1);
         checkOutput("wr2 wr_ready", 64'(wrReady8), 64'(!pat[c]));
         if (!pat[c]) k++;
         step();
      end
      waitReq = 1'b0;
      wrValid = 1'b0;
      #1;
      checkOutput("wr2 done", 64'(done8), 64'd1);
      step();

      // Zero-length command completes without bus traffic.
      applyStimulus(1'b0, 1'b0, 25'h77, 8'd0);
      #1;
      checkOutput("len0 done", 64'(done8), 64'd1);
      checkOutput("len0 no request", 64'({avmRead8, avmWrite8, cs8}), 64'd0);
      checkOutput("len0 busy", 64'(busy8), 64'd0);
      step();
      #1;
      checkOutput("len0 done cleared", 64'(done8), 64'd0);
      checkOutput("len0 cmd_ready", 64'(cmdReady8), 64'd1);
      step();

      // Pipelined read, 3-cycle slave latency.
      lat8 = 3;
      s  = rdQ8.size();
      d0 = doneCnt8;
      applyStimulus(1'b0, 1'b0, 25'h100, 8'd8);
      waitDone(1'b0, 100, "rd8 done seen");
      step();
      step();
      checkOutput("rd8 beat count", 64'(rdQ8.size() - s), 64'd8);
      for (int i = 0; i < 8 && s + i < rdQ8.size(); i++)
         checkOutput("rd8 data", 64'(rdQ8[s + i]), 64'(memWord(25'h100 + 25'(i))));
      checkOutput("rd8 done once", 64'(doneCnt8 - d0), 64'd1);
      checkOutput("rd8 max outstanding", 64'(maxOut8), 64'd3);

      // Read across the top of the address space.
      lat8 = 2;
      s  = rdQ8.size();
      si = issAddr8.size();
      applyStimulus(1'b0, 1'b0, 25'h1FF_FFFE, 8'd4);
      waitDone(1'b0, 100, "wrap done seen");
      step();
      checkOutput("wrap issue count", 64'(issAddr8.size() - si), 64'd4);
      for (int i = 0; i < 4 && si + i < issAddr8.size(); i++)
         checkOutput("wrap address", 64'(issAddr8[si + i]), 64'(wrapExp[i]));
      for (int i = 0; i < 4 && s + i < rdQ8.size(); i++)
         checkOutput("wrap data", 64'(rdQ8[s + i]), 64'(memWord(wrapExp[i])));

      // Two reads in flight at most, slow slave.
      lat2 = 10;
      applyStimulus(1'b1, 1'b0, 25'h200, 8'd6);
      waitDone(1'b1, 300, "mo2 done seen");
      step();
      checkOutput("mo2 beat count", 64'(rdQ2.size()), 64'd6);
      for (int i = 0; i < 6 && i < rdQ2.size(); i++)
         checkOutput("mo2 data", 64'(rdQ2[i]), 64'(memWord(25'h200 + 25'(i))));
      checkOutput("mo2 max outstanding", 64'(maxOut2), 64'd2);
      checkOutput("mo2 read while full", 64'(viol2), 64'd0);
      checkOutput("mo2 stalled when full", 64'(fullStall2 > 0), 64'd1);
      checkOutput("mo2 done once", 64'(doneCnt2), 64'd1);

      // Reset with three reads in flight; their late returns must be ignored.
      lat8 = 6;
      s  = rdQ8.size();
      d0 = doneCnt8;
      applyStimulus(1'b0, 1'b0, 25'h300, 8'd8);
      step();
      step();
      #1;
      checkOutput("abort reading", 64'(avmRead8), 64'd1);
      rst = 1'b1;
      step();
      #1;
      checkOutput("abort read dropped", 64'({avmRead8, avmWrite8, cs8}), 64'd0);
      checkOutput("abort byteenable", 64'(be8), 64'd0);
      checkOutput("abort busy", 64'(busy8), 64'd0);
      checkOutput("abort cmd_ready", 64'(cmdReady8), 64'd1);
      rst = 1'b0;
      for (int c = 0; c < 15; c++) step();
      checkOutput("abort no rd_valid", 64'(rdQ8.size() - s), 64'd0);
      checkOutput("abort no done", 64'(doneCnt8 - d0), 64'd0);
      checkOutput("abort idle", 64'(cmdReady8), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
